alarm_bank: RTL and testbench

Multi-slot alarm engine replacing the single-alarm setter/trigger pair: holds `N_ALARMS` independently programmable BCD alarm times and rings on the first-minute match of any enabled slot. Adds snooze with a bounded repeat count, auto-silence after a ring timeout, write validation and missed-alarm reporting. Sits between the timekeeping core, which supplies the current BCD time and `tick_1s`, and the UI/buzzer logic.

---
 rtl/alarm_bank.sv | 198 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm engine: per-slot first-minute match detection, lowest-index
// priority, ring/snooze/auto-silence FSM, validated writes and missed-alarm reporting.
module alarm_bank #(
    parameter int N_ALARMS       = 4,
    parameter int SLOT_W         = 2,
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1s,
    input  logic [15:0]       cur_time,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [15:0]       wr_time,
    input  logic              wr_enable,
    output logic              wr_err,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [15:0]       rd_time,
    output logic              rd_enable,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              alarm_triggered,
    output logic              alarm_active,
    output logic              alarm_snoozed,
    output logic [SLOT_W-1:0] active_slot,
    output logic [3:0]        snooze_count,
    output logic              missed
);

    localparam int unsigned N_SLOTS    = 1 << SLOT_W;
    localparam logic [15:0] RESET_TIME = 16'h0700;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    function automatic logic bcd_time_valid(input logic [15:0] t);
        logic [3:0] ht, ho, mt, mo;
        ht = t[15:12];
        ho = t[11:8];
        mt = t[7:4];
        mo = t[3:0];
        return (ht <= 4'd2) && (ho <= 4'd9) && (mt <= 4'd5) && (mo <= 4'd9) &&
               !((ht == 4'd2) && (ho > 4'd3));
    endfunction

    logic [15:0]        slot_time_r [N_SLOTS];
    logic [N_SLOTS-1:0] slot_en_r;
    logic [N_SLOTS-1:0] match_d_r;
    logic [N_SLOTS-1:0] match_s;
    logic [N_SLOTS-1:0] fire_s;
    logic [SLOT_W-1:0]  win_slot_s;
    logic               any_fire_s;
    logic               multi_fire_s;
    logic               wr_valid_s;
    logic               slot_ok_s;
    logic               disable_active_s;

    state_t             state_r;
    logic [15:0]        timer_r;
    logic [3:0]         snooze_count_r;
    logic [SLOT_W-1:0]  active_slot_r;
    logic               alarm_triggered_r;
    logic               alarm_active_r;
    logic               alarm_snoozed_r;
    logic               missed_r;
    logic               wr_err_r;

    // Write qualification and the "active slot is being disabled" condition.
    always_comb begin
        slot_ok_s        = (32'(wr_slot) < 32'(N_ALARMS));
        wr_valid_s       = wr_en & slot_ok_s & bcd_time_valid(wr_time);
        disable_active_s = wr_valid_s & ~wr_enable & (wr_slot == active_slot_r);
    end

    // Per-slot rising-match detection and lowest-index winner selection.
    always_comb begin
        match_s    = '0;
        fire_s     = '0;
        win_slot_s = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            match_s[k] = (cur_time == slot_time_r[k]);
            if (k < N_ALARMS) begin
                fire_s[k] = match_s[k] & ~match_d_r[k] & slot_en_r[k];
            end else begin
                fire_s[k] = 1'b0;
            end
            win_slot_s = fire_s[k] ? SLOT_W'(k) : win_slot_s;
        end
        any_fire_s   = |fire_s;
        multi_fire_s = |(fire_s & (fire_s - N_SLOTS'(1)));
    end

    // Slot storage and match history; writes are seen by match logic next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_time_r[k] <= RESET_TIME;
            end
            slot_en_r <= '0;
            match_d_r <= '0;
        end else begin
            match_d_r <= match_s;
            if (wr_valid_s) begin
                slot_time_r[wr_slot] <= wr_time;
                slot_en_r[wr_slot]   <= wr_enable;
            end
        end
    end

    // Alarm event FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= IDLE;
            timer_r           <= 16'd0;
            snooze_count_r    <= 4'd0;
            active_slot_r     <= '0;
            alarm_triggered_r <= 1'b0;
            alarm_active_r    <= 1'b0;
            alarm_snoozed_r   <= 1'b0;
            missed_r          <= 1'b0;
            wr_err_r          <= 1'b0;
        end else begin
            alarm_triggered_r <= 1'b0;
            missed_r          <= 1'b0;
            wr_err_r          <= wr_en & ~wr_valid_s;
            case (state_r)
                IDLE: begin
                    if (any_fire_s) begin
                        state_r           <= RINGING;
                        alarm_active_r    <= 1'b1;
                        active_slot_r     <= win_slot_s;
                        timer_r           <= 16'd0;
                        snooze_count_r    <= 4'd0;
                        alarm_triggered_r <= 1'b1;
                        missed_r          <= multi_fire_s;
                    end
                end
                RINGING: begin
                    missed_r <= any_fire_s;
                    if (stop_btn || disable_active_s) begin
                        state_r        <= IDLE;
                        alarm_active_r <= 1'b0;
                    end else if (snooze_btn && (snooze_count_r < 4'(MAX_SNOOZE))) begin
                        state_r         <= SNOOZED;
                        alarm_active_r  <= 1'b0;
                        alarm_snoozed_r <= 1'b1;
                        timer_r         <= 16'd0;
                        snooze_count_r  <= snooze_count_r + 4'd1;
                    end else if (tick_1s) begin
                        timer_r <= timer_r + 16'd1;
                        if ((timer_r + 16'd1) == 16'(RING_TIMEOUT_S)) begin
                            state_r        <= IDLE;
                            alarm_active_r <= 1'b0;
                        end
                    end
                end
                SNOOZED: begin
                    missed_r <= any_fire_s;
                    if (stop_btn || disable_active_s) begin
                        state_r         <= IDLE;
                        alarm_snoozed_r <= 1'b0;
                    end else if (tick_1s) begin
                        if ((timer_r + 16'd1) == 16'(SNOOZE_S)) begin
                            state_r           <= RINGING;
                            alarm_snoozed_r   <= 1'b0;
                            alarm_active_r    <= 1'b1;
                            timer_r           <= 16'd0;
                            alarm_triggered_r <= 1'b1;
                        end else begin
                            timer_r <= timer_r + 16'd1;
                        end
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    alarm_active_r  <= 1'b0;
                    alarm_snoozed_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd_time         = slot_time_r[rd_slot];
    assign rd_enable       = slot_en_r[rd_slot];
    assign wr_err          = wr_err_r;
    assign alarm_triggered = alarm_triggered_r;
    assign alarm_active    = alarm_active_r;
    assign alarm_snoozed   = alarm_snoozed_r;
    assign active_slot     = active_slot_r;
    assign snooze_count    = snooze_count_r;
    assign missed          = missed_r;

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed scenarios, a write-validation vector table and
// randomized traffic, all compared against an event-level reference model.
module tb_alarm_bank;

    localparam int RT = 3;
    localparam int SN = 2;
    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_1s = 1'b0;
    logic [15:0] cur_time = 16'h0000;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_slot = 2'd0;
    logic [15:0] wr_time = 16'h0000;
    logic        wr_enable = 1'b0;
    logic        wr_err;
    logic [1:0]  rd_slot = 2'd0;
    logic [15:0] rd_time;
    logic        rd_enable;
    logic        snooze_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic        alarm_triggered, alarm_active, alarm_snoozed, missed;
    logic [1:0]  active_slot;
    logic [3:0]  snooze_count;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 ringing, 2 snoozed
    int m_time [4];
    bit m_en   [4];
    bit m_prev [4];
    int m_state, m_timer, m_cnt, m_slot;
    bit m_trig, m_missed, m_err;

    alarm_bank #(.N_ALARMS(4), .SLOT_W(2), .SNOOZE_S(SN), .RING_TIMEOUT_S(RT), .MAX_SNOOZE(MS)) dut (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .cur_time(cur_time),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_time(wr_time), .wr_enable(wr_enable),
        .wr_err(wr_err), .rd_slot(rd_slot), .rd_time(rd_time), .rd_enable(rd_enable),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn), .alarm_triggered(alarm_triggered),
        .alarm_active(alarm_active), .alarm_snoozed(alarm_snoozed), .active_slot(active_slot),
        .snooze_count(snooze_count), .missed(missed)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit time_ok(input logic [15:0] t);
        int ht = int'(t[15:12]);
        int ho = int'(t[11:8]);
        int mt = int'(t[7:4]);
        int mo = int'(t[3:0]);
        return ht <= 9 && ho <= 9 && mt <= 9 && mo <= 9 && (ht * 10 + ho) <= 23 && (mt * 10 + mo) <= 59;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_time[k] = 'h0700;
            m_en[k]   = 1'b0;
            m_prev[k] = 1'b0;
        end
        m_state = 0; m_timer = 0; m_cnt = 0; m_slot = 0;
        m_trig = 0; m_missed = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit valid, dis;
        int nfire, first;
        valid = wr_en && time_ok(wr_time) && (int'(wr_slot) < 4);
        dis   = valid && !wr_enable && (int'(wr_slot) == m_slot);
        nfire = 0; first = -1;
        for (int k = 0; k < 4; k++) begin
            bit match = (int'(cur_time) == m_time[k]);
            if (match && !m_prev[k] && m_en[k]) begin
                nfire++;
                if (first < 0) first = k;
            end
            m_prev[k] = match;
        end
        m_trig = 0; m_missed = 0; m_err = wr_en && !valid;
        if (m_state == 0) begin
            if (nfire > 0) begin
                m_state = 1; m_slot = first; m_timer = 0; m_cnt = 0; m_trig = 1;
                m_missed = (nfire > 1);
            end
        end else if (m_state == 1) begin
            m_missed = (nfire > 0);
            if (stop_btn || dis) m_state = 0;
            else if (snooze_btn && m_cnt < MS) begin
                m_state = 2; m_timer = 0; m_cnt++;
            end else if (tick_1s) begin
                m_timer++;
                if (m_timer == RT) m_state = 0;
            end
        end else begin
            m_missed = (nfire > 0);
            if (stop_btn || dis) m_state = 0;
            else if (tick_1s) begin
                m_timer++;
                if (m_timer == SN) begin
                    m_state = 1; m_timer = 0; m_trig = 1;
                end
            end
        end
        if (valid) begin
            m_time[wr_slot] = int'(wr_time);
            m_en[wr_slot]   = wr_enable;
        end
    endtask

    // Applies the currently driven inputs for one clock and compares against the model.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("alarm_triggered", alarm_triggered, m_trig);
        chk("missed", missed, m_missed);
        chk("wr_err", wr_err, m_err);
        chk("alarm_active", alarm_active, m_state == 1);
        chk("alarm_snoozed", alarm_snoozed, m_state == 2);
        if (m_state != 0) begin
            chk("active_slot", active_slot, m_slot);
            chk("snooze_count", snooze_count, m_cnt);
        end
        chk("rd_time", rd_time, m_time[rd_slot]);
        chk("rd_enable", rd_enable, m_en[rd_slot]);
        wr_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; tick_1s = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] t, input logic e);
        wr_en = 1'b1; wr_slot = s; wr_time = t; wr_enable = e;
        cyc();
    endtask

    typedef struct {
        logic [1:0]  slot;
        logic [15:0] t;
        logic        exp_err;
        logic [15:0] exp_rd;
    } wvec_t;

    wvec_t wv [8];
    logic [15:0] pool [5];

    initial begin
        wv[0] = '{2'd3, 16'h2400, 1'b1, 16'h0700};
        wv[1] = '{2'd3, 16'h1260, 1'b1, 16'h0700};
        wv[2] = '{2'd3, 16'h1A00, 1'b1, 16'h0700};
        wv[3] = '{2'd3, 16'h2359, 1'b0, 16'h2359};
        wv[4] = '{2'd3, 16'h0000, 1'b0, 16'h0000};
        wv[5] = '{2'd3, 16'h2360, 1'b1, 16'h0000};
        wv[6] = '{2'd3, 16'h0A00, 1'b1, 16'h0000};
        wv[7] = '{2'd3, 16'h0959, 1'b0, 16'h0959};
        pool[0] = 16'h0630; pool[1] = 16'h1200; pool[2] = 16'h0700;
        pool[3] = 16'h2359; pool[4] = 16'h0000;

        model_reset();
        #12;
        chk("reset alarm_active", alarm_active, 0);
        chk("reset alarm_snoozed", alarm_snoozed, 0);
        chk("reset alarm_triggered", alarm_triggered, 0);
        chk("reset missed", missed, 0);
        chk("reset wr_err", wr_err, 0);
        chk("reset active_slot", active_slot, 0);
        chk("reset snooze_count", snooze_count, 0);
        chk("reset rd_time", rd_time, 'h0700);
        chk("reset rd_enable", rd_enable, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // basic ring on slot 1
        rd_slot = 2'd1;
        wr(2'd1, 16'h0630, 1'b1);
        cur_time = 16'h0629; cyc();
        cur_time = 16'h0630; cyc();
        chk("ring trig", alarm_triggered, 1);
        chk("ring active", alarm_active, 1);
        chk("ring slot", active_slot, 1);
        cyc();
        chk("ring trig one-shot", alarm_triggered, 0);

        // auto-silence after RT ticks
        tick_1s = 1'b1; cyc();
        tick_1s = 1'b1; cyc();
        chk("timeout still active", alarm_active, 1);
        tick_1s = 1'b1; cyc();
        chk("timeout active", alarm_active, 0);
        chk("timeout no trig", alarm_triggered, 0);

        // snooze twice, third snooze ignored
        cur_time = 16'h0631; cyc();
        cur_time = 16'h0630; cyc();
        chk("snz ring", alarm_active, 1);
        snooze_btn = 1'b1; cyc();
        chk("snz1 snoozed", alarm_snoozed, 1);
        chk("snz1 count", snooze_count, 1);
        tick_1s = 1'b1; cyc();
        chk("snz1 waiting", alarm_snoozed, 1);
        tick_1s = 1'b1; cyc();
        chk("rering1 trig", alarm_triggered, 1);
        chk("rering1 active", alarm_active, 1);
        snooze_btn = 1'b1; cyc();
        tick_1s = 1'b1; cyc();
        tick_1s = 1'b1; cyc();
        chk("rering2 trig", alarm_triggered, 1);
        snooze_btn = 1'b1; cyc();
        chk("snz limit active", alarm_active, 1);
        chk("snz limit count", snooze_count, 2);
        stop_btn = 1'b1; cyc();
        chk("stop active", alarm_active, 0);

        // two slots fire together: lowest wins, one missed pulse
        wr(2'd0, 16'h1200, 1'b1);
        wr(2'd2, 16'h1200, 1'b1);
        cur_time = 16'h1200; cyc();
        chk("prio trig", alarm_triggered, 1);
        chk("prio slot", active_slot, 0);
        chk("prio missed", missed, 1);
        stop_btn = 1'b1; cyc();

        // write validation table
        cur_time = 16'h0000; cyc();
        for (int i = 0; i < 8; i++) begin
            rd_slot = wv[i].slot;
            wr(wv[i].slot, wv[i].t, 1'b0);
            chk($sformatf("wvec%0d wr_err", i), wr_err, wv[i].exp_err);
            chk($sformatf("wvec%0d rd_time", i), rd_time, wv[i].exp_rd);
        end

        // enabling a slot whose minute is already current does not fire
        cur_time = 16'h0800; cyc();
        wr(2'd3, 16'h0800, 1'b0);
        cyc();
        wr(2'd3, 16'h0800, 1'b1);
        cyc();
        chk("enable-in-minute active", alarm_active, 0);

        // stop + snooze together while ringing
        cur_time = 16'h1159; cyc();
        cur_time = 16'h1200; cyc();
        chk("ss ring", alarm_active, 1);
        stop_btn = 1'b1; snooze_btn = 1'b1; cyc();
        chk("ss active", alarm_active, 0);
        chk("ss snoozed", alarm_snoozed, 0);

        // disabling the active slot ends the event
        cur_time = 16'h1159; cyc();
        cur_time = 16'h1200; cyc();
        chk("dis ring slot", active_slot, 0);
        wr(2'd0, 16'h1200, 1'b0);
        chk("dis active", alarm_active, 0);

        // reset while snoozed (slot 2 still armed)
        cur_time = 16'h1159; cyc();
        cur_time = 16'h1200; cyc();
        chk("rst ring slot", active_slot, 2);
        snooze_btn = 1'b1; cyc();
        chk("rst snoozed before", alarm_snoozed, 1);
        rd_slot = 2'd2;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst snoozed", alarm_snoozed, 0);
        chk("rst active", alarm_active, 0);
        chk("rst count", snooze_count, 0);
        chk("rst slot", active_slot, 0);
        chk("rst rd_enable", rd_enable, 0);
        chk("rst rd_time", rd_time, 'h0700);
        #3;
        reset_n = 1'b1;
        cyc();
        chk("rst release no trig", alarm_triggered, 0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) cur_time = pool[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) begin
                wr_en     = 1'b1;
                wr_slot   = 2'($urandom_range(0, 3));
                wr_time   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 4)] : 16'($urandom);
                wr_enable = ($urandom_range(0, 2) != 0);
            end
            snooze_btn = ($urandom_range(0, 5) == 0);
            stop_btn   = ($urandom_range(0, 19) == 0);
            tick_1s    = ($urandom_range(0, 1) == 0);
            rd_slot    = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
